fft_agu_seq: RTL and testbench
==============================

Name: fft_agu_seq

Overview:
Parametrised address generation unit for the in-place radix-2 constant-geometry FFT engine; the successor of the fixed 32-point AGU.
- Sequences all stages and butterflies of one transform per start command.
- Issues butterfly pair addresses ja/jb and a twiddle ROM address over a valid/ready handshake to the butterfly datapath.
- Reports stage, last-butterfly and done status to the FFT controller.

Parameters:
LOG2N, 5, log2 of transform size; N = 2^LOG2N points, LOG2N stages, N/2 butterflies per stage; legal range 2..12
TW_W, LOG2N-1, twiddle address width (derived; do not override)
STG_W, $clog2(LOG2N) (min 1), stage counter width (derived)

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request to run a full transform; honoured only when idle
addr_ready  in  1  datapath accepts the current address set
addr_valid  out  1  ja/jb/tw_addr/stage/last valid
ja  out  LOG2N  butterfly upper address
jb  out  LOG2N  butterfly lower address
tw_addr  out  TW_W  twiddle ROM address
stage  out  STG_W  stage of the current address set, 0..LOG2N-1
last  out  1  high with the final address set of the transform
phase  out  1  0 = butterfly phase, 1 = load phase (AGU_BITREV_LOAD_EN only)
busy  out  1  transform in progress
done  out  1  one-cycle pulse after the final transfer

Behaviour:
- Reset (asynchronous, reset_n low): state IDLE; every output 0; counters b and s cleared. Reset mid-transform aborts immediately with no done pulse.
- States: IDLE, LOAD (macro only), RUN, DONE.
- IDLE: start=1 goes to RUN (or LOAD); b=0, s=0. Next cycle addr_valid=1 and busy=1. Start-to-first-valid latency is exactly 1 cycle.
- A transfer occurs on any cycle with addr_valid && addr_ready.
  - On a transfer, b increments. At b = N/2-1, b wraps to 0 and s increments.
  - At s = LOG2N-1 with b = N/2-1, the transfer goes to DONE.
- addr_ready low: all outputs hold stable; no counter moves. addr_valid never drops before its transfer.
- Address generation, all registered and all from the same counter values:
  - ja = rotate-left within LOG2N bits of (2*b) by s.
  - jb = rotate-left of (2*b+1) by s.
  - tw_addr = b AND mask, where mask keeps the top s bits of the TW_W-bit field; s=0 gives 0, s=LOG2N-1 gives all bits.
- last = 1 iff s = LOG2N-1 and b = N/2-1.
- DONE: addr_valid=0, busy=0, done=1 for exactly one cycle, then IDLE.
- start while busy or in DONE is ignored; it is not queued.
- Total transfers per transform: LOG2N*N/2 (80 for LOG2N=5). With addr_ready tied high, start-to-done is LOG2N*N/2+1 cycles.

Optional Feature:
AGU_BITREV_LOAD_EN
- Defined: start enters LOAD first.
  - Issues N transfers with phase=1, ja = bit-reverse of load index i (0..N-1), jb=0, tw_addr=0, stage=0, last=0, same handshake.
  - After i=N-1 is accepted, enters RUN with phase=0 and no bubble.
  - Transform length becomes N + LOG2N*N/2 transfers.
- Undefined: LOAD state absent; phase tied 0.

Test Plan:
- LOG2N=5, reset then start, addr_ready=1 -> cycle after start: ja=0, jb=1, tw_addr=0, stage=0, valid=1; done exactly 81 cycles after start; 80 transfers counted.
- Stage 1, b=3 -> ja=12, jb=14, tw_addr=0. Stage 4, b=15 -> ja=15, jb=31, tw_addr=15, last=1. Next cycle done=1, busy=0.
- Random addr_ready toggling (about 50% low) -> outputs stable while ready low; full sequence identical to the ready-high run; done only after transfer 80.
- start pulsed at transfer 20 mid-transform -> ignored; count still 80, single done. reset_n asserted at transfer 40 -> outputs 0 asynchronously, no done; a following start restarts at ja=0, jb=1.
- LOG2N=3 and LOG2N=8 -> transfer count 12 and 1024; each stage's ja/jb sets cover 0..N-1 exactly once.
- AGU_BITREV_LOAD_EN, LOG2N=5 -> first 32 transfers phase=1 with i=1 giving ja=16 and i=3 giving ja=24; then butterfly sequence; done after 112 transfers.

Source files
------------

// File: rtl/fft_agu_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------------
// fft_agu_seq: constant-geometry radix-2 FFT address generator (ja/jb/twiddle),
// optional bit-reversed load pass under macro AGU_BITREV_LOAD_EN. Revision: 1.0
// ---------------------------------------------------------------------------------
module fft_agu_seq #(
  parameter int LOG2N = 5,
  parameter int TW_W  = LOG2N - 1,
  parameter int STG_W = (LOG2N > 1) ? $clog2(LOG2N) : 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             addr_ready,
  output logic             addr_valid,
  output logic [LOG2N-1:0] ja,
  output logic [LOG2N-1:0] jb,
  output logic [TW_W-1:0]  tw_addr,
  output logic [STG_W-1:0] stage,
  output logic             last,
  output logic             phase,
  output logic             busy,
  output logic             done
);

  localparam logic [TW_W-1:0]  B_MAX = '1;
  localparam logic [STG_W-1:0] S_MAX = STG_W'(LOG2N - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic logic [LOG2N-1:0] rotl(input logic [LOG2N-1:0] x,
                                            input logic [STG_W-1:0] sh);
    logic [LOG2N-1:0] r;
    r = x;
    for (int k = 0; k < LOG2N; k++)
      if (k < int'(sh)) r = {r[LOG2N-2:0], r[LOG2N-1]};
    return r;
  endfunction

  // Keeps the top sh bits of the twiddle field.
  function automatic logic [TW_W-1:0] tw_mask(input logic [STG_W-1:0] sh);
    logic [TW_W-1:0] m;
    m = '0;
    for (int k = 0; k < TW_W; k++)
      if (k >= TW_W - int'(sh)) m[k] = 1'b1;
    return m;
  endfunction

  state_t           state_q, state_d;
  logic [TW_W-1:0]  b_q, b_d;
  logic [STG_W-1:0] s_q, s_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [LOG2N-1:0] ja_q, ja_d;
  logic [LOG2N-1:0] jb_q, jb_d;
  logic [TW_W-1:0]  tw_q, tw_d;
  logic [STG_W-1:0] stage_q, stage_d;
  logic             last_q, last_d;
  logic             upd_bfly;

`ifdef AGU_BITREV_LOAD_EN
  localparam logic [LOG2N-1:0] I_MAX = '1;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] x);
    logic [LOG2N-1:0] r;
    for (int k = 0; k < LOG2N; k++) r[k] = x[LOG2N-1-k];
    return r;
  endfunction

  logic [LOG2N-1:0] i_q, i_d;
  logic             phase_q, phase_d;
  assign phase = phase_q;
`else
  assign phase = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    b_d      = b_q;
    s_d      = s_q;
    valid_d  = valid_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    ja_d     = ja_q;
    jb_d     = jb_q;
    tw_d     = tw_q;
    stage_d  = stage_q;
    last_d   = last_q;
    upd_bfly = 1'b0;
`ifdef AGU_BITREV_LOAD_EN
    i_d      = i_q;
    phase_d  = phase_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          b_d     = '0;
          s_d     = '0;
          valid_d = 1'b1;
          busy_d  = 1'b1;
`ifdef AGU_BITREV_LOAD_EN
          state_d = ST_LOAD;
          i_d     = '0;
          phase_d = 1'b1;
          ja_d    = '0;
          jb_d    = '0;
          tw_d    = '0;
          stage_d = '0;
          last_d  = 1'b0;
`else
          state_d  = ST_RUN;
          upd_bfly = 1'b1;
`endif
        end
      end
`ifdef AGU_BITREV_LOAD_EN
      ST_LOAD: begin
        if (addr_ready) begin
          if (i_q == I_MAX) begin
            state_d  = ST_RUN;
            phase_d  = 1'b0;
            upd_bfly = 1'b1;
          end else begin
            i_d  = i_q + 1'b1;
            ja_d = bitrev(i_d);
          end
        end
      end
`endif
      ST_RUN: begin
        if (addr_ready) begin
          if (last_q) begin
            state_d = ST_DONE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            ja_d    = '0;
            jb_d    = '0;
            tw_d    = '0;
            stage_d = '0;
            last_d  = 1'b0;
          end else begin
            if (b_q == B_MAX) begin
              b_d = '0;
              s_d = s_q + 1'b1;
            end else begin
              b_d = b_q + 1'b1;
            end
            upd_bfly = 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Every address field is derived from the same next-counter values.
    if (upd_bfly) begin
      ja_d    = rotl({b_d, 1'b0}, s_d);
      jb_d    = rotl({b_d, 1'b1}, s_d);
      tw_d    = b_d & tw_mask(s_d);
      stage_d = s_d;
      last_d  = (b_d == B_MAX) && (s_d == S_MAX);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      b_q     <= '0;
      s_q     <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ja_q    <= '0;
      jb_q    <= '0;
      tw_q    <= '0;
      stage_q <= '0;
      last_q  <= 1'b0;
`ifdef AGU_BITREV_LOAD_EN
      i_q     <= '0;
      phase_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      b_q     <= b_d;
      s_q     <= s_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ja_q    <= ja_d;
      jb_q    <= jb_d;
      tw_q    <= tw_d;
      stage_q <= stage_d;
      last_q  <= last_d;
`ifdef AGU_BITREV_LOAD_EN
      i_q     <= i_d;
      phase_q <= phase_d;
`endif
    end
  end

  assign addr_valid = valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign ja         = ja_q;
  assign jb         = jb_q;
  assign tw_addr    = tw_q;
  assign stage      = stage_q;
  assign last       = last_q;

endmodule
`default_nettype wire

// File: tb/tb_fft_agu_seq.sv
`default_nettype none
// tb_fft_agu_seq: scoreboard bench; a reference transfer list per transform is
// queued at start and a negedge monitor pops and compares every accepted transfer.
module tb_fft_agu_seq;
  localparam int LG = 5;
  localparam int N  = 1 << LG;
  localparam int TW = LG - 1;
  localparam int SW = $clog2(LG);
`ifdef AGU_BITREV_LOAD_EN
  localparam int TOTAL = N + LG * N / 2;
`else
  localparam int TOTAL = LG * N / 2;
`endif
  localparam int BUDGET = TOTAL * 10 + 50;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          addr_ready = 1'b0;
  logic          addr_valid;
  logic [LG-1:0] ja, jb;
  logic [TW-1:0] tw_addr;
  logic [SW-1:0] stage;
  logic          last, phase, busy, done;

  fft_agu_seq #(.LOG2N(LG)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .addr_ready(addr_ready),
    .addr_valid(addr_valid), .ja(ja), .jb(jb), .tw_addr(tw_addr), .stage(stage),
    .last(last), .phase(phase), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int xfers = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  logic [63:0] q[$];
  int seen[LG][N];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] pack(input logic ph, input logic [LG-1:0] a,
                                       input logic [LG-1:0] b, input logic [TW-1:0] t,
                                       input logic [SW-1:0] s, input logic l);
    return 64'({ph, a, b, t, s, l});
  endfunction

  function automatic logic [63:0] outs_all();
    return 64'({addr_valid, busy, done, phase, ja, jb, tw_addr, stage, last});
  endfunction

  // Reference model: plain arithmetic over the transform's transfer list.
  function automatic void push_expected();
    int x0, x1, t, sh;
`ifdef AGU_BITREV_LOAD_EN
    for (int i = 0; i < N; i++) begin
      int r;
      r = 0;
      for (int k = 0; k < LG; k++) if (((i >> k) & 1) == 1) r += 1 << (LG - 1 - k);
      q.push_back(pack(1'b1, LG'(r), '0, '0, '0, 1'b0));
    end
`endif
    for (int s = 0; s < LG; s++) begin
      for (int b = 0; b < N / 2; b++) begin
        x0 = 2 * b;
        x1 = 2 * b + 1;
        x0 = ((x0 << s) | (x0 >> (LG - s))) % N;
        x1 = ((x1 << s) | (x1 >> (LG - s))) % N;
        sh = TW - s;
        t  = (b >> sh) << sh;
        q.push_back(pack(1'b0, LG'(x0), LG'(x1), TW'(t), SW'(s),
                         (s == LG - 1) && (b == N / 2 - 1)));
      end
    end
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor
  initial begin
    logic        hold_v;
    logic [63:0] snap, exp;
    int          bad;
    hold_v = 1'b0;
    snap   = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        hold_v = 1'b0;
      end else begin
        if (hold_v) chk("hold_stable", outs_all(), snap);
        hold_v = addr_valid && !addr_ready;
        snap   = outs_all();
        if (addr_valid && addr_ready) begin
          chk("xfer_expected_avail", 64'(q.size() != 0), 64'd1);
          if (q.size() != 0) begin
            exp = q.pop_front();
            chk("xfer", pack(phase, ja, jb, tw_addr, stage, last), exp);
          end
          if (!phase) begin
            seen[stage][ja]++;
            seen[stage][jb]++;
          end
          xfers++;
        end
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
          chk("done_after_last", 64'(xfers), 64'(TOTAL));
          chk("done_valid_busy", 64'({addr_valid, busy}), 64'd0);
          chk("done_queue_empty", 64'(q.size()), 64'd0);
          bad = 0;
          for (int s = 0; s < LG; s++)
            for (int a = 0; a < N; a++) if (seen[s][a] != 1) bad++;
          chk("stage_cover", 64'(bad), 64'd0);
        end
      end
    end
  end

  // One transform; caller sits #1 after a rising edge.
  task automatic run(input int pct_low, input bit mid_start, input int abort_at,
                     input bit poke_done);
    int t0, d0;
    bit pulsed, saw_done;
    pulsed = 1'b0;
    saw_done = 1'b0;
    xfers = 0;
    d0 = done_cnt;
    foreach (seen[s, a]) seen[s][a] = 0;
    push_expected();
    start = 1'b1;
    addr_ready = ($urandom_range(99) >= pct_low);
    t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    chk("first_valid_busy", 64'({addr_valid, busy}), 64'd3);
    for (int k = 0; k < BUDGET; k++) begin
      if (done) begin
        saw_done = 1'b1;
        if (poke_done) begin
          start = 1'b1;
          @(posedge clk); #1;
          start = 1'b0;
          chk("start_in_done_ignored", 64'({addr_valid, busy}), 64'd0);
        end
        break;
      end
      addr_ready = ($urandom_range(99) >= pct_low);
      if (mid_start && !pulsed && xfers >= 20) begin
        start = 1'b1;
        pulsed = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (abort_at > 0 && xfers >= abort_at) begin
        reset_n = 1'b0;
        #1;
        chk("abort_outputs_zero", outs_all(), 64'd0);
        q.delete();
        repeat (3) @(posedge clk);
        #1;
        chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
        reset_n = 1'b1;
        start = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    @(posedge clk); #1;
    chk("done_seen", 64'(saw_done), 64'd1);
    chk("xfer_count", 64'(xfers), 64'(TOTAL));
    chk("done_pulses", 64'(done_cnt - d0), 64'd1);
    if (pct_low == 0) chk("start_to_done", 64'(done_cyc - t0), 64'(TOTAL + 1));
    q.delete();
  endtask

  initial begin
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", outs_all(), 64'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_outputs", outs_all(), 64'd0);
    run(0, 1'b0, 0, 1'b1);
    run(50, 1'b1, 0, 1'b0);
    run(50, 1'b0, 40, 1'b0);
    run(0, 1'b0, 0, 1'b0);
    run(30, 1'b1, 0, 1'b1);
    run(50, 1'b0, 0, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
